// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
//  Module      : im_loader
//  Description : Serial byte-stream loader for the instruction memory.
//                Stream: 16-bit word count N (high byte first), then 4*N
//                data bytes (each word MSB first), then one checksum byte
//                when LOADER_CHECKSUM_EN is defined. Holds the core in
//                reset until the load completes.
//  Options     : LOADER_CHECKSUM_EN - adds the CHK state and a modulo-256
//                running sum of all length and data bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module im_loader #(
    parameter int MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        im_we_o,
    output logic [9:0]  im_addr_o,
    output logic [31:0] im_wdata_o,
    output logic        cpu_reset_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [2:0]  c_LEN_HI = 3'd0;
    localparam logic [2:0]  c_LEN_LO = 3'd1;
    localparam logic [2:0]  c_DATA   = 3'd2;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0]  c_CHK    = 3'd3;
`endif
    localparam logic [2:0]  c_DONE   = 3'd4;
    localparam logic [2:0]  c_ERR    = 3'd5;
    localparam logic [16:0] c_MAX    = 17'(MAX_WORDS);

    logic [2:0]  r_state;
    logic [15:0] r_count;
    logic [9:0]  r_word_idx;
    logic [1:0]  r_byte_cnt;
    // Only the first three bytes of a word need storing; the fourth is
    // taken straight from byte_i when the word is written.
    logic [23:0] r_asm;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  r_sum;
`endif

    logic        w_accept;
    logic [15:0] w_len;
    logic [31:0] w_word;
    logic        w_last;

    assign w_accept = byte_valid_i & byte_ready_o;
    assign w_len    = {r_count[15:8], byte_i};
    assign w_word   = {r_asm, byte_i};
    assign w_last   = ({6'd0, r_word_idx} == (r_count - 16'd1));

    // Loader state machine with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_LEN_HI;
            r_count      <= '0;
            r_word_idx   <= '0;
            r_byte_cnt   <= '0;
            r_asm        <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_sum        <= '0;
`endif
            byte_ready_o <= 1'b1;
            im_we_o      <= 1'b0;
            im_addr_o    <= '0;
            im_wdata_o   <= '0;
            cpu_reset_o  <= 1'b1;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            im_we_o <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            if (w_accept && (r_state != c_CHK)) begin
                r_sum <= r_sum + byte_i;
            end
`endif
            case (r_state)
                c_LEN_HI: begin
                    if (w_accept) begin
                        r_count[15:8] <= byte_i;
                        r_state       <= c_LEN_LO;
                    end
                end
                c_LEN_LO: begin
                    if (w_accept) begin
                        r_count[7:0] <= byte_i;
                        if ((w_len == 16'd0) || ({1'b0, w_len} > c_MAX)) begin
                            r_state      <= c_ERR;
                            byte_ready_o <= 1'b0;
                            err_o        <= 1'b1;
                        end else begin
                            r_state <= c_DATA;
                        end
                    end
                end
                c_DATA: begin
                    if (w_accept) begin
                        r_asm      <= w_word[23:0];
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            im_we_o    <= 1'b1;
                            im_addr_o  <= r_word_idx;
                            im_wdata_o <= w_word;
                            r_word_idx <= r_word_idx + 10'd1;
                            if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
                                r_state      <= c_CHK;
`else
                                r_state      <= c_DONE;
                                byte_ready_o <= 1'b0;
`endif
                            end
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                c_CHK: begin
                    if (w_accept) begin
                        byte_ready_o <= 1'b0;
                        if (byte_i == r_sum) begin
                            r_state <= c_DONE;
                        end else begin
                            r_state <= c_ERR;
                            err_o   <= 1'b1;
                        end
                    end
                end
`endif
                c_DONE: begin
                    // Entered on the last write edge, so done_o and the core
                    // release land one cycle after the final strobe.
                    done_o      <= 1'b1;
                    cpu_reset_o <= 1'b0;
                end
                c_ERR: begin
                    err_o <= 1'b1;
                end
                default: begin
                    r_state      <= c_ERR;
                    byte_ready_o <= 1'b0;
                    err_o        <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_im_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_im_loader
//  Description : Self-checking bench for im_loader with a write scoreboard.
//                Follows LOADER_CHECKSUM_EN to append the checksum byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_im_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic        im_we_o;
    logic [9:0]  im_addr_o;
    logic [31:0] im_wdata_o;
    logic        cpu_reset_o;
    logic        done_o;
    logic        err_o;

    int          n_total;
    int          n_bad;
    int          n_strobes;
    logic [41:0] exp_q[$];
    logic [31:0] mem[1024];
    logic [9:0]  addr_snap;
    logic [31:0] data_snap;

    im_loader #(.MAX_WORDS(1024)) dut (
        .clk          (clk),
        .reset        (reset),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .im_we_o      (im_we_o),
        .im_addr_o    (im_addr_o),
        .im_wdata_o   (im_wdata_o),
        .cpu_reset_o  (cpu_reset_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (im_we_o) begin
            n_strobes++;
            if (exp_q.size() == 0) begin
                check("spurious_we", 32'd1, 32'd0);
            end else begin
                logic [41:0] e;
                e = exp_q.pop_front();
                check("we_addr", {22'd0, im_addr_o}, {22'd0, e[41:32]});
                check("we_data", im_wdata_o, e[31:0]);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte is taken.
    task automatic send(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                byte_valid_i = 1'b0;
                byte_i       = 8'($urandom);
                @(negedge clk);
            end
        end
        byte_valid_i = 1'b1;
        byte_i       = b;
        t = 0;
        while (!byte_ready_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        byte_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        byte_valid_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Sends a full stream of n words from mem[], expecting a clean load.
    task automatic load(input int n, input bit gaps);
        logic [7:0]  s;
        logic [15:0] len;
        logic [7:0]  b;
        len = 16'(n);
        s   = len[15:8] + len[7:0];
        send(len[15:8], gaps);
        send(len[7:0], gaps);
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = mem[w][31 - 8*k -: 8];
                s = s + b;
                if (k == 3) exp_q.push_back({10'(w), mem[w]});
                send(b, gaps);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send(s, gaps);
`endif
    endtask

    initial begin
        n_total = 0; n_bad = 0; n_strobes = 0;
        reset = 1'b1; byte_valid_i = 1'b0; byte_i = 8'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset values
        check("rst_ready", {31'd0, byte_ready_o}, 32'd1);
        check("rst_we", {31'd0, im_we_o}, 32'd0);
        check("rst_addr", {22'd0, im_addr_o}, 32'd0);
        check("rst_wdata", im_wdata_o, 32'd0);
        check("rst_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);

        // Single word, back-to-back
        mem[0] = 32'h20080005;
        load(1, 1'b0);
        check("one_done_lag", {31'd0, done_o}, 32'd0);
        check("one_ready_off", {31'd0, byte_ready_o}, 32'd0);
        @(negedge clk);
        check("one_done", {31'd0, done_o}, 32'd1);
        check("one_cpu_rel", {31'd0, cpu_reset_o}, 32'd0);
        check("one_err", {31'd0, err_o}, 32'd0);
        check("one_q_empty", exp_q.size(), 32'd0);

        // Bytes offered in DONE are ignored
        addr_snap = im_addr_o; data_snap = im_wdata_o;
        byte_valid_i = 1'b1; byte_i = 8'hA5;
        repeat (4) @(negedge clk);
        byte_valid_i = 1'b0;
        check("done_hold", {31'd0, done_o}, 32'd1);
        check("done_ready", {31'd0, byte_ready_o}, 32'd0);
        check("done_addr", {22'd0, im_addr_o}, {22'd0, addr_snap});
        check("done_wdata", im_wdata_o, data_snap);

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum
        do_reset();
        send(8'h00, 1'b0); send(8'h01, 1'b0);
        exp_q.push_back({10'd0, 32'h20080005});
        send(8'h20, 1'b0); send(8'h08, 1'b0); send(8'h00, 1'b0); send(8'h05, 1'b0);
        send(8'h2F, 1'b0);
        @(negedge clk);
        check("chk_err", {31'd0, err_o}, 32'd1);
        check("chk_no_done", {31'd0, done_o}, 32'd0);
        check("chk_cpu_held", {31'd0, cpu_reset_o}, 32'd1);
`endif

        // Zero length
        do_reset();
        send(8'h00, 1'b0); send(8'h00, 1'b0);
        check("len0_err", {31'd0, err_o}, 32'd1);
        check("len0_ready", {31'd0, byte_ready_o}, 32'd0);
        // Bytes offered in ERR are ignored
        byte_valid_i = 1'b1; byte_i = 8'h11;
        repeat (3) @(negedge clk);
        byte_valid_i = 1'b0;
        check("err_hold", {31'd0, err_o}, 32'd1);
        check("err_cpu_held", {31'd0, cpu_reset_o}, 32'd1);

        // Length one past the maximum
        do_reset();
        send(8'h04, 1'b0); send(8'h01, 1'b0);
        check("len1025_err", {31'd0, err_o}, 32'd1);
        check("len1025_done", {31'd0, done_o}, 32'd0);

        // Full-depth load with random gaps
        do_reset();
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        n_strobes = 0;
        load(1024, 1'b1);
        repeat (2) @(negedge clk);
        check("full_strobes", n_strobes, 32'd1024);
        check("full_last_addr", {22'd0, im_addr_o}, 32'h3FF);
        check("full_done", {31'd0, done_o}, 32'd1);
        check("full_q_empty", exp_q.size(), 32'd0);

        // Reset after the third byte of word 5
        do_reset();
        for (int i = 0; i < 8; i++) mem[i] = $urandom;
        send(8'h00, 1'b0); send(8'h08, 1'b0);
        for (int w = 0; w < 5; w++) begin
            for (int k = 0; k < 4; k++) begin
                if (k == 3) exp_q.push_back({10'(w), mem[w]});
                send(mem[w][31 - 8*k -: 8], 1'b0);
            end
        end
        for (int k = 0; k < 3; k++) send(mem[5][31 - 8*k -: 8], 1'b0);
        n_strobes = 0;
        do_reset();
        @(negedge clk);
        check("abort_no_we", n_strobes, 32'd0);
        check("abort_ready", {31'd0, byte_ready_o}, 32'd1);
        check("abort_cpu_held", {31'd0, cpu_reset_o}, 32'd1);
        check("abort_done", {31'd0, done_o}, 32'd0);
        mem[0] = 32'hDEADBEEF; mem[1] = 32'h01234567;
        load(2, 1'b1);
        repeat (2) @(negedge clk);
        check("reload_strobes", n_strobes, 32'd2);
        check("reload_done", {31'd0, done_o}, 32'd1);
        check("reload_q_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter MAX_WORDS, default 1024, meaning: instruction-memory depth in 32-bit words; the block accepts word counts up to this value.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 byte_i  input  8  serial program byte.
REQ-005 byte_valid_i  input  1  byte_i holds a valid byte.
REQ-006 byte_ready_o  output  1  the loader can accept a byte this cycle.
REQ-007 im_we_o  output  1  one-cycle instruction-memory write strobe.
REQ-008 im_addr_o  output  10  word address, the same indexing as PC[11:2].
REQ-009 im_wdata_o  output  32  instruction word to write.
REQ-010 cpu_reset_o  output  1  holds the mips core in reset until loading completes.
REQ-011 done_o  output  1  load completed successfully (sticky).
REQ-012 err_o  output  1  load aborted on error (sticky).

Function
REQ-013 A byte SHALL be accepted only on a rising edge where byte_valid_i and byte_ready_o are both 1; bytes with byte_valid_i low are ignored, and gaps of any length are allowed.
REQ-014 The FSM SHALL have these states: LEN_HI, LEN_LO, DATA, CHK, DONE, ERR.
REQ-015 byte_ready_o SHALL be 1 in LEN_HI, LEN_LO, DATA and CHK, and 0 in DONE and ERR.
REQ-016 Stream format SHALL be: word count N as 16 bits, high byte first; then 4*N data bytes, each word MSB first; then one checksum byte only when CHECKSUM_EN is defined.
REQ-017 LEN_HI SHALL capture N[15:8] and go to LEN_LO; LEN_LO SHALL capture N[7:0] and go to DATA, or go to ERR if N==0 or N>MAX_WORDS.
REQ-018 In DATA, each byte SHALL shift into a 32-bit assembly register; a 2-bit byte counter wraps 3->0.
REQ-019 On acceptance of the 4th byte of a word, im_we_o SHALL be 1 for exactly the next cycle, with im_addr_o equal to the word index and im_wdata_o equal to the assembled word.
REQ-020 The word index SHALL start at 0 and increment by 1 after each write.
REQ-021 byte_ready_o SHALL stay 1 during a write-strobe cycle, so back-to-back bytes are never stalled.
REQ-022 After the write of word N-1, the FSM SHALL go to CHK (macro defined) or DONE (macro undefined).
REQ-023 done_o SHALL rise the cycle after the final im_we_o pulse, so that memory is valid before the core runs.
REQ-024 cpu_reset_o SHALL be 1 in every state except DONE, and fall in the same cycle done_o rises.
REQ-025 DONE and ERR SHALL be terminal; only reset leaves them.
REQ-026 im_we_o SHALL be 0 in every cycle other than those defined in REQ-019.
REQ-027 A partially assembled word SHALL never be written.

Reset
REQ-028 While reset=1, the next edge SHALL clear state to LEN_HI and clear the count, word index, byte counter, assembly register and checksum.
REQ-029 Reset values SHALL be: byte_ready_o=1 after the reset cycle, im_we_o=0, im_addr_o=0, im_wdata_o=0, cpu_reset_o=1, done_o=0, err_o=0.
REQ-030 Reset asserted mid-load, including during a write-strobe cycle, SHALL abort the load; previously written words remain in memory but are not re-signalled.
REQ-031 Reset SHALL take priority over a simultaneous byte acceptance.

Configuration
REQ-032 With macro LOADER_CHECKSUM_EN defined, the block SHALL keep an 8-bit modulo-256 running sum of all accepted length and data bytes.
REQ-033 With LOADER_CHECKSUM_EN defined, CHK SHALL accept one byte: equal to the sum -> DONE on the next edge; unequal -> ERR.
REQ-034 With LOADER_CHECKSUM_EN undefined, CHK and the sum register SHALL be absent, and DATA SHALL go directly to DONE.

Verification
REQ-035 No macro; bytes 00 01 20 08 00 05 back-to-back -> single im_we_o with addr 0 and data 0x20080005; done_o=1 and cpu_reset_o=0 one cycle later; byte_ready_o=0 thereafter.
REQ-036 Macro defined; same bytes plus 2E -> done_o=1; plus 2F instead -> err_o=1, done_o=0, cpu_reset_o stays 1.
REQ-037 Length 00 00 -> err_o=1 after the 2nd byte with no write; length 04 01 -> err_o=1 with no write.
REQ-038 N=1024, random words, byte_valid_i toggled randomly -> 1024 strobes at addr 0..0x3FF in order with matching data; last address 0x3FF; no addr wrap.
REQ-039 Reset asserted after the 3rd byte of word 5 -> no strobe for word 5; state LEN_HI; a fresh 2-word load then writes addr 0 and 1 correctly.
REQ-040 Bytes offered with byte_valid_i=1 in DONE or ERR -> not accepted; im_we_o stays 0; outputs unchanged.
